sub_pipe: RTL and testbench

SUB_PIPE -- requirements
Module: sub_pipe

---
 rtl/arith_pkg.sv | 15 +
 rtl/arith_adder.sv | 55 +++++
 rtl/arith_reg.sv | 30 +++
 rtl/sub_pipe_stage.sv | 59 +++++
 rtl/sub_pipe.sv | 128 ++++++++++++
 tb/tb_sub_pipe.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions.
//   alg_e   : adder implementation select (ALG_RCA ripple-carry, ALG_CLA look-ahead)
//   is_pow2 : constant helper for parameter checks
package arith_pkg;

  typedef enum int unsigned {
    ALG_RCA = 0,
    ALG_CLA = 1
  } alg_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/arith_adder.sv
// Combinational WIDTH-bit adder: {cout, sum} = a + b + cin.
//   ALGORITHM : ALG_RCA ripple-carry, ALG_CLA carry-look-ahead
//   a, b, cin : operands and carry in
//   sum, cout : result and carry out
module arith_adder import arith_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ALGORITHM = ALG_RCA
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  if (ALGORITHM == ALG_CLA) begin : g_cla
    logic cla_c;
    logic cla_t;
    // Each carry is a flat sum of generate terms propagated to bit i,
    // so no carry depends on a lower computed carry.
    always_comb begin
      c     = '0;
      cla_c = 1'b0;
      cla_t = 1'b0;
      c[0]  = cin;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cla_c = cin;
        for (int unsigned m = 0; m <= i; m++) cla_c = cla_c & p[m];
        for (int unsigned j = 0; j <= i; j++) begin
          cla_t = g[j];
          for (int unsigned m = j + 1; m <= i; m++) cla_t = cla_t & p[m];
          cla_c = cla_c | cla_t;
        end
        c[i+1] = cla_c;
      end
    end
  end else begin : g_rca
    always_comb begin
      c    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < WIDTH; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/arith_reg.sv
// Enable-gated register with asynchronous active-low clear.
//   clk, rst_n : clock, async active-low reset (clears q)
//   en         : load d when 1, hold otherwise
//   d, q       : WIDTH-bit data in / registered data out
module arith_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/sub_pipe_stage.sv
// One pipeline segment of sub_pipe: registered SEG_W-bit subtractor.
//   clk, rst_n          : clock, async active-low reset
//   en                  : pipeline advance; registers hold when 0
//   a, b                : segment minuend / subtrahend
//   borrow_in           : borrow from previous segment (or block bin)
//   diff, borrow_out    : registered segment difference and borrow
module sub_pipe_stage import arith_pkg::*; #(
  parameter int unsigned SEG_W     = 4,
  parameter int unsigned ALGORITHM = ALG_RCA
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             borrow_in,
  output logic [SEG_W-1:0] diff,
  output logic             borrow_out
);

  logic [SEG_W-1:0] sum;
  logic             carry;
  logic [SEG_W-1:0] diff_d;
  logic [SEG_W-1:0] diff_q;
  logic             borrow_d;
  logic             borrow_q;

  // a - b - borrow_in == a + ~b + ~borrow_in; borrow is the inverted carry.
  arith_adder #(.WIDTH(SEG_W), .ALGORITHM(ALGORITHM)) u_add (
    .a    (a),
    .b    (~b),
    .cin  (~borrow_in),
    .sum  (sum),
    .cout (carry)
  );

  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (en) begin
      diff_d   = sum;
      borrow_d = ~carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: rtl/sub_pipe.sv
// Pipelined WIDTH-bit subtractor split into NUM_STAGES segments with
// valid/ready handshake. diff = in0 - in1 - bin (mod 2^WIDTH), bout = borrow.
// Latency NUM_STAGES cycles, one result per cycle, whole pipe stalls together.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid, in_ready         : input handshake (in_ready = advance)
//   in0, in1, bin              : minuend, subtrahend, borrow in
//   out_valid, out_ready       : output handshake
//   diff, bout                 : difference, borrow out
// Build option: define SUB_PIPE_SAT_EN to clamp diff to 0 when bout=1.
module sub_pipe import arith_pkg::*; #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ALGORITHM  = ALG_RCA
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  if (!is_pow2(NUM_STAGES)) begin : g_bad_stages
    $fatal(1, "sub_pipe: NUM_STAGES=%0d must be a power of 2 and >= 1", NUM_STAGES);
  end else if ((WIDTH % NUM_STAGES) != 0) begin : g_bad_width
    $fatal(1, "sub_pipe: WIDTH=%0d not divisible by NUM_STAGES=%0d", WIDTH, NUM_STAGES);
  end
  if (ALGORITHM > ALG_CLA) begin : g_bad_alg
    $fatal(1, "sub_pipe: unsupported ALGORITHM=%0d", ALGORITHM);
  end

  localparam int unsigned SEG_W = WIDTH / NUM_STAGES;

  logic                  advance;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] valid_q;
  logic [SEG_W-1:0]      stage_a    [NUM_STAGES];
  logic [SEG_W-1:0]      stage_b    [NUM_STAGES];
  logic [SEG_W-1:0]      stage_diff [NUM_STAGES];
  logic                  stage_bout [NUM_STAGES];
  logic [WIDTH-1:0]      diff_aligned;
  logic                  bout_final;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[NUM_STAGES-1];

  always_comb begin
    valid_d = valid_q;
    if (advance) begin
      valid_d[0] = in_valid;
      for (int unsigned i = 1; i < NUM_STAGES; i++) valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_seg
    localparam int unsigned DLY = NUM_STAGES - 1 - k;

    logic             borrow_in;
    logic [SEG_W-1:0] dsk [DLY+1];

    if (k == 0) begin : g_direct
      assign stage_a[k] = in0[SEG_W-1:0];
      assign stage_b[k] = in1[SEG_W-1:0];
      assign borrow_in  = bin;
    end else begin : g_skew
      // Operand segment k waits k cycles so it meets the borrow from stage k-1.
      logic [2*SEG_W-1:0] skew [k+1];
      assign skew[0] = {in1[k*SEG_W +: SEG_W], in0[k*SEG_W +: SEG_W]};
      for (genvar j = 0; j < k; j++) begin : g_reg
        arith_reg #(.WIDTH(2*SEG_W)) u_reg (
          .clk   (clk),
          .rst_n (rst_n),
          .en    (advance),
          .d     (skew[j]),
          .q     (skew[j+1])
        );
      end
      assign stage_a[k] = skew[k][SEG_W-1:0];
      assign stage_b[k] = skew[k][2*SEG_W-1:SEG_W];
      assign borrow_in  = stage_bout[k-1];
    end

    sub_pipe_stage #(.SEG_W(SEG_W), .ALGORITHM(ALGORITHM)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (advance),
      .a          (stage_a[k]),
      .b          (stage_b[k]),
      .borrow_in  (borrow_in),
      .diff       (stage_diff[k]),
      .borrow_out (stage_bout[k])
    );

    // Earlier segments finish early; delay them to line up with the last one.
    assign dsk[0] = stage_diff[k];
    for (genvar j = 0; j < DLY; j++) begin : g_dly
      arith_reg #(.WIDTH(SEG_W)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .d     (dsk[j]),
        .q     (dsk[j+1])
      );
    end
    assign diff_aligned[k*SEG_W +: SEG_W] = dsk[DLY];
  end

  assign bout_final = stage_bout[NUM_STAGES-1];
  assign bout       = bout_final;

`ifdef SUB_PIPE_SAT_EN
  assign diff = bout_final ? '0 : diff_aligned;
`else
  assign diff = diff_aligned;
`endif

endmodule

// File: tb/tb_sub_pipe.sv
module tb_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [15:0] in0, in1, diff;
  logic        in_valid_s, in_ready_s, bin_s, out_valid_s, out_ready_s, bout_s;
  logic [15:0] in0_s, in1_s, diff_s;

  int checks = 0;
  int fails  = 0;
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  sub_pipe #(.WIDTH(16), .NUM_STAGES(4), .ALGORITHM(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .bin(bin), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .bout(bout)
  );

  sub_pipe #(.WIDTH(16), .NUM_STAGES(1), .ALGORITHM(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in0(in0_s), .in1(in1_s), .bin(bin_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .diff(diff_s), .bout(bout_s)
  );

  // Reference: {bout, diff} from plain integer arithmetic.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    int unsigned ai, bi, d;
    logic        br;
    ai = a;
    bi = b + c;
    br = (ai < bi);
    d  = (ai + 32'h10000 - bi) % 32'h10000;
`ifdef SUB_PIPE_SAT_EN
    if (br) d = 0;
`endif
    return {br, d[15:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; out_ready = 1; in0 = '0; in1 = '0; bin = 0;
    in_valid_s = 0; out_ready_s = 1; in0_s = '0; in1_s = '0; bin_s = 0;
    #3;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (diff !== 16'h0) begin fails++; $display("FAIL reset_diff: got %h expected 0000", diff); end
    checks++; if (bout !== 1'b0) begin fails++; $display("FAIL reset_bout: got %b expected 0", bout); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid_s !== 1'b0) begin fails++; $display("FAIL reset_out_valid_s: got %b expected 0", out_valid_s); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'h1234, 16'h0000, 16'h1000, 16'h0005};
    logic [15:0] vb [4] = '{16'h0234, 16'h0001, 16'h0001, 16'h0005};
    logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [16:0] e;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in0 = va[i]; in1 = vb[i]; bin = vc[i]; out_ready = 1;
      e = ref_sub(va[i], vb[i], vc[i]);
      #1;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 4) begin fails++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (diff !== e[15:0]) begin fails++; $display("FAIL dir%0d_diff: got %h expected %h", i, diff, e[15:0]); end
      checks++; if (bout !== e[16]) begin fails++; $display("FAIL dir%0d_bout: got %b expected %b", i, bout, e[16]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_no_dup: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] oa [8];
    logic [15:0] ob [8];
    logic        oc [8];
    logic [16:0] e;
    int sent = 0, got = 0, extra = 0;
    for (int i = 0; i < 8; i++) begin
      oa[i] = 16'($urandom_range(0, 65535));
      ob[i] = 16'($urandom_range(0, 65535));
      oc[i] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    for (int c = 0; c < 60 && got < 8; c++) begin
      in_valid = 1'b0;
      if (sent < 8) begin in_valid = 1'b1; in0 = oa[sent]; in1 = ob[sent]; bin = oc[sent]; end
      out_ready = !(c >= 5 && c <= 7);
      #1;
      if (!out_ready && out_valid) begin
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, in_ready); end
        checks++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL stall_hold c%0d: got %h with no result pending", c, diff); end
        else if ({bout, diff} !== exp_q[0]) begin
          fails++; $display("FAIL stall_hold c%0d: got %b/%h expected %b/%h", c, bout, diff, exp_q[0][16], exp_q[0][15:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL stream_extra c%0d: got %h with none expected", c, diff); end
        else begin
          e = exp_q.pop_front();
          if ({bout, diff} !== e) begin
            fails++; $display("FAIL stream_result%0d: got %b/%h expected %b/%h", got, bout, diff, e[16], e[15:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(in0, in1, bin));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got != 8) begin fails++; $display("FAIL stream_count: got %0d expected 8", got); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra != 0) begin fails++; $display("FAIL stream_dup: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_midflight();
    logic [16:0] e;
    int lat;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in0 = 16'($urandom_range(0, 65535)); in1 = 16'($urandom_range(0, 65535)); bin = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL inflight_valid: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %b expected 0", out_valid); end
    checks++; if (diff !== 16'h0) begin fails++; $display("FAIL async_rst_diff: got %h expected 0000", diff); end
    checks++; if (bout !== 1'b0) begin fails++; $display("FAIL async_rst_bout: got %b expected 0", bout); end
    #1 rst_n = 1'b1;
    in_valid = 1; in0 = 16'h8001; in1 = 16'h7fff; bin = 1; out_ready = 1;
    e = ref_sub(in0, in1, bin);
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 4) begin fails++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    checks++; if ({bout, diff} !== e) begin
      fails++; $display("FAIL post_rst_result: got %b/%h expected %b/%h", bout, diff, e[16], e[15:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_stage();
    logic [16:0] e;
    in_valid_s = 1; in0_s = 16'hFFFF; in1_s = 16'h0001; bin_s = 0; out_ready_s = 1;
    e = ref_sub(in0_s, in1_s, bin_s);
    @(posedge clk); #1;
    checks++; if (out_valid_s !== 1'b1) begin fails++; $display("FAIL s1_latency: got out_valid %b expected 1", out_valid_s); end
    checks++; if ({bout_s, diff_s} !== e) begin
      fails++; $display("FAIL s1_result: got %b/%h expected %b/%h", bout_s, diff_s, e[16], e[15:0]);
    end
    for (int i = 0; i < 6; i++) begin
      in0_s = 16'($urandom_range(0, 65535)); in1_s = 16'($urandom_range(0, 65535)); bin_s = 1'($urandom_range(0, 1));
      e = ref_sub(in0_s, in1_s, bin_s);
      @(posedge clk); #1;
      checks++; if (out_valid_s !== 1'b1 || {bout_s, diff_s} !== e) begin
        fails++; $display("FAIL s1_stream%0d: got v%b %b/%h expected v1 %b/%h", i, out_valid_s, bout_s, diff_s, e[16], e[15:0]);
      end
    end
    in_valid_s = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_single_stage();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
